// File: rtl/shifter_pipe.sv
// Pipelined log-shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready on both sides.
// Define SHIFTER_PIPE_TAG_EN to carry a TAG_W-bit sideband tag alongside each item.
module shifter_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         in_a_i,
    input  logic [$clog2(XLEN)-1:0] in_shamt_i,
    input  logic [2:0]              in_op_i,
`ifdef SHIFTER_PIPE_TAG_EN
    input  logic [TAG_W-1:0]        in_tag_i,
    output logic [TAG_W-1:0]        out_tag_o,
`endif
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         out_data_o
);
    localparam int unsigned L    = $clog2(XLEN);
    localparam int unsigned CtlN = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic [2:0] OpSll = 3'b000;
    localparam logic [2:0] OpSrl = 3'b001;
    localparam logic [2:0] OpSra = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;
    localparam logic [2:0] OpRor = 3'b101;

    if (XLEN < 8 || XLEN > 64 || (XLEN & (XLEN - 1)) != 0 || STAGES < 1 || STAGES > L ||
        TAG_W < 1) begin : g_bad_params
        $error("shifter_pipe: unsupported parameter combination");
    end

    // One log-shifter level: shift by 2^k. SRA fill uses the current MSB, which
    // earlier SRA levels have kept equal to the original sign bit.
    function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] x,
                                                     input logic [2:0] op,
                                                     input int unsigned k);
        int unsigned sh;
        sh = 32'd1 << k;
        case (op)
            OpSll:   shift_level = x << sh;
            OpSrl:   shift_level = x >> sh;
            OpSra:   shift_level = $signed(x) >>> sh;
            OpRol:   shift_level = (x << sh) | (x >> (XLEN - sh));
            OpRor:   shift_level = (x >> sh) | (x << (XLEN - sh));
            default: shift_level = x;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] shift_stage(input logic [XLEN-1:0] x,
                                                     input logic [2:0] op,
                                                     input logic [L-1:0] shamt,
                                                     input int unsigned lo,
                                                     input int unsigned hi);
        logic [XLEN-1:0] r;
        r = x;
        for (int unsigned k = 0; k < L; k++) begin
            if (k >= lo && k < hi && shamt[k]) r = shift_level(r, op, k);
        end
        return r;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_v;
    logic [XLEN-1:0]   data_q    [STAGES];
    logic [XLEN-1:0]   src_data  [STAGES];
    logic [XLEN-1:0]   res       [STAGES];
    logic [2:0]        src_op    [STAGES];
    logic [L-1:0]      src_shamt [STAGES];
    logic [2:0]        op_q      [CtlN];
    logic [L-1:0]      shamt_q   [CtlN];

    // A stage loads when empty or when its downstream neighbour takes its item.
    always_comb begin
        logic acc;
        load = '0;
        acc  = out_ready_i;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            acc     = !v_q[s] || acc;
            load[s] = acc;
        end
    end

    assign in_ready_o = load[0] && !rst_i;

    always_comb begin
        src_v[0]     = in_valid_i;
        src_data[0]  = in_a_i;
        src_op[0]    = in_op_i;
        src_shamt[0] = in_shamt_i;
        for (int s = 1; s < int'(STAGES); s++) begin
            src_v[s]     = v_q[s-1];
            src_data[s]  = data_q[s-1];
            src_op[s]    = op_q[s-1];
            src_shamt[s] = shamt_q[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned Lo = (s * L) / STAGES;
        localparam int unsigned Hi = ((s + 1) * L) / STAGES;
        assign res[s] = shift_stage(src_data[s], src_op[s], src_shamt[s], Lo, Hi);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int s = 0; s < int'(STAGES); s++) data_q[s] <= '0;
            for (int s = 0; s < int'(CtlN); s++) begin
                op_q[s]    <= '0;
                shamt_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (load[s]) begin
                    v_q[s] <= src_v[s];
                    if (src_v[s]) data_q[s] <= res[s];
                end
            end
            for (int s = 0; s < int'(STAGES) - 1; s++) begin
                if (load[s] && src_v[s]) begin
                    op_q[s]    <= src_op[s];
                    shamt_q[s] <= src_shamt[s];
                end
            end
        end
    end

`ifdef SHIFTER_PIPE_TAG_EN
    logic [TAG_W-1:0] tag_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(STAGES); s++) tag_q[s] <= '0;
        end else begin
            if (load[0] && in_valid_i) tag_q[0] <= in_tag_i;
            for (int s = 1; s < int'(STAGES); s++) begin
                if (load[s] && v_q[s-1]) tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign out_tag_o = tag_q[STAGES-1];
`endif

    assign out_valid_o = v_q[STAGES-1];
    assign out_data_o  = data_q[STAGES-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and streaming checks for shifter_pipe at XLEN=32, STAGES=2.
module tb_shifter_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef SHIFTER_PIPE_TAG_EN
    logic [4:0]  in_tag;
    logic [4:0]  out_tag;
`endif

    int n_total = 0;
    int n_bad   = 0;

    shifter_pipe #(
        .XLEN   (32),
        .STAGES (2),
        .TAG_W  (5)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_shamt_i  (in_shamt),
        .in_op_i     (in_op),
`ifdef SHIFTER_PIPE_TAG_EN
        .in_tag_i    (in_tag),
        .out_tag_o   (out_tag),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [2:0] op,
                                              input logic [4:0] sh);
        logic [63:0] w;
        w = {a, a};
        case (op)
            3'b000:  return a << sh;
            3'b001:  return a >> sh;
            3'b011:  return $signed(a) >>> sh;
            3'b100:  begin w = w << sh; return w[63:32]; end
            3'b101:  begin w = w >> sh; return w[31:0]; end
            default: return a;
        endcase
    endfunction

    task automatic run_single(input string tag, input logic [31:0] a, input logic [2:0] op,
                              input logic [4:0] sh, input logic [31:0] exp);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_op = op; in_shamt = sh;
        #1;
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_eq(tag, out_data, exp);
    endtask

    logic [31:0] va [17] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h12345678,
                             32'h80000001, 32'h12345678, 32'h12345678, 32'h12345678,
                             32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                             32'h7FFFFFF0, 32'h12345678, 32'hF0000000, 32'hF0000000,
                             32'h12345678};
    logic [2:0]  vo [17] = '{3'b000, 3'b011, 3'b001, 3'b101, 3'b100, 3'b000, 3'b001,
                             3'b011, 3'b100, 3'b101, 3'b111, 3'b010, 3'b011, 3'b100,
                             3'b001, 3'b011, 3'b100};
    logic [4:0]  vs [17] = '{5'd31, 5'd31, 5'd31, 5'd8, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0,
                             5'd0, 5'd5, 5'd13, 5'd4, 5'd4, 5'd4, 5'd4, 5'd28};
    logic [31:0] ve [17] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h78123456,
                             32'h00000003, 32'h12345678, 32'h12345678, 32'h12345678,
                             32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                             32'h07FFFFFF, 32'h23456781, 32'h0F000000, 32'hFF000000,
                             32'h81234567};

    initial begin
        int          idx;
        int          got_n;
        int          cycles;
        int          n_in;
        int          n_out;
        int          first_out;
        int          last_out;
        logic [31:0] held;
        logic        have_held;
        logic        stale;
        logic [31:0] got [4];
        logic [31:0] exp_q [$];
        logic [4:0]  tag_q [$];
        logic [4:0]  cur_tag;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
        cur_tag = '0;
`ifdef SHIFTER_PIPE_TAG_EN
        in_tag = '0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 17; i++) run_single($sformatf("vec%0d", i), va[i], vo[i], vs[i], ve[i]);

        // Backpressure: out_ready low for 5 cycles while offering 4 items.
        idx = 0; have_held = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (idx < 4); in_a = 32'd1; in_op = 3'b000; in_shamt = 5'(idx);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                if (!have_held) begin
                    held = out_data;
                    have_held = 1'b1;
                end else begin
                    check_eq("bp_hold", out_data, held);
                end
            end
        end
        check_eq("bp_accepted", 32'(idx), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        check_eq("bp_head", out_data, 32'd1);
        got_n = 0; cycles = 0;
        for (int c = 0; c < 20 && got_n < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 4); in_shamt = 5'(idx);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                got[got_n] = out_data;
                got_n++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        check_eq("bp_count", 32'(got_n), 32'd4);
        check_eq("bp_cycles", 32'(cycles), 32'd4);
        for (int i = 0; i < got_n; i++) check_eq($sformatf("bp_item%0d", i), got[i], 32'd1 << i);

        // Reset with two items in flight.
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h5; in_op = 3'b000; in_shamt = 5'd1;
        @(negedge clk);
        in_a = 32'h9;
        @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_out_data", out_data, 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale = 1'b1;
        end
        check_eq("rst_no_stale", 32'(stale), 32'd0);

        // Streaming random items with the consumer always ready.
        n_in = 0; n_out = 0; first_out = -1; last_out = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && n_out < 100; c++) begin
            @(negedge clk);
            if (n_in < 100) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_op    = 3'($urandom_range(0, 7));
                in_shamt = 5'($urandom_range(0, 31));
                cur_tag  = 5'($urandom_range(0, 31));
`ifdef SHIFTER_PIPE_TAG_EN
                in_tag   = cur_tag;
`endif
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_extra", 32'(out_valid), 32'd0);
                end else begin
                    check_eq($sformatf("stream%0d", n_out), out_data, exp_q.pop_front());
`ifdef SHIFTER_PIPE_TAG_EN
                    check_eq($sformatf("stream_tag%0d", n_out), 32'(out_tag),
                             32'(tag_q.pop_front()));
`else
                    void'(tag_q.pop_front());
`endif
                end
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_a, in_op, in_shamt));
                tag_q.push_back(cur_tag);
                n_in++;
            end
        end
        in_valid = 1'b0;
        check_eq("stream_count", 32'(n_out), 32'd100);
        check_eq("stream_first", 32'(first_out), 32'd2);
        check_eq("stream_last", 32'(last_out), 32'd101);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor of the core's combinational ALU shifter.
- Performs logical left, logical right, arithmetic right, rotate left and rotate right on an XLEN-bit operand.
- Uses a valid/ready handshake on both sides and a configurable number of register stages.
- Sits between the decode/issue stage and writeback as a fixed-latency execution unit.

Parameters:
- XLEN, 32: operand width in bits; power of two, 8..64.
- STAGES, 2: number of registered pipeline stages; 1..$clog2(XLEN).
- TAG_W, 5: width of the sideband tag. Used only when the optional feature is enabled.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit accepts the operand this cycle.
- in_a  input  XLEN  operand.
- in_shamt  input  $clog2(XLEN)  shift amount, unsigned.
- in_op  input  3  operation: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; all other codes are pass-through (result = in_a).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  XLEN  result.
- in_tag  input  TAG_W  sideband tag. Present only with SHIFTER_PIPE_TAG_EN.
- out_tag  output  TAG_W  tag aligned with out_data. Present only with SHIFTER_PIPE_TAG_EN.

Behaviour:
- Reset: asynchronous. While rst=1: every stage valid bit =0, out_valid=0, out_data=0, out_tag=0, in_ready=0. Operand registers may reset to 0.
- Reset mid-operation: all in-flight items are discarded. Nothing is emitted after rst deasserts until new inputs are accepted.
- Transfer rule: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Shifter structure: a log-shifter with L=$clog2(XLEN) levels, where level k shifts by 2^k when in_shamt[k]=1. Stage s (0..STAGES-1) implements levels floor(s*L/STAGES) through floor((s+1)*L/STAGES)-1.
- Pipeline registers: the op code, remaining shamt bits and the partial result are registered at the end of each stage.
- Latency: an item accepted in cycle t is presented on out_valid/out_data in cycle t+STAGES, provided no stall occurs.
- Throughput: one item per cycle while out_ready=1.
- Stage advance rule:
  - Stage s holds a valid bit.
  - Stage s loads from upstream when it is empty or when stage s+1 (or the output, for the last stage) takes its item this cycle.
  - in_ready = !v0 || stage 0 advancing. Bubbles collapse, so in_ready stays high while any bubble exists ahead.
- Backpressure: while out_ready=0, out_valid and out_data are held stable. The pipeline fills to STAGES items, then in_ready=0. No item is lost, duplicated or reordered.
- Arithmetic rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with in_a[XLEN-1].
  - ROL/ROR: bits wrap modulo XLEN. ROL by n equals ROR by (XLEN-n) mod XLEN.
  - shamt=0: every op returns in_a.
  - Only the low $clog2(XLEN) bits of the shift amount exist, so a shift by XLEN or more is impossible by construction.
- Simultaneous events: an output transfer and an input transfer in the same cycle with a full pipeline is legal. The pipeline shifts and stays full.
- out_data is taken from the final stage register. No combinational path runs from in_* to out_*.
- in_ready depends combinationally on out_ready.

Optional Feature:
- Macro: SHIFTER_PIPE_TAG_EN.
- Defined: the in_tag/out_tag ports exist. The tag travels with its item through every stage and follows the same stall and reset rules, so out_tag is always aligned with out_data.
- Undefined: the ports, the tag registers and the TAG_W logic are absent. The rest of the behaviour is identical.

Test Plan:
- XLEN=32, STAGES=2:
  - SLL a=0x00000001 shamt=31 -> out_data=0x80000000 exactly 2 cycles after acceptance.
  - SRA a=0x80000000 shamt=31 -> 0xFFFFFFFF.
  - SRL with the same inputs -> 0x00000001.
- Rotates:
  - ROR a=0x12345678 shamt=8 -> 0x78123456.
  - ROL a=0x80000001 shamt=1 -> 0x00000003.
  - shamt=0 on all five ops -> 0x12345678 unchanged.
  - in_op=111 -> pass-through.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while offering 4 back-to-back items.
  - Required: in_ready drops after 2 acceptances and out_data stays stable.
  - On release, all 4 results arrive in order, one per cycle, with none lost or duplicated.
- Reset mid-operation: assert rst asynchronously (mid-cycle) with 2 items in flight -> out_valid=0 immediately. After deassertion, no stale result appears.
- Streaming: 100 random ops/operands with out_ready=1, compared against a reference model -> all match, one result per cycle after a 2-cycle fill. With SHIFTER_PIPE_TAG_EN, out_tag matches the tag sent with each item.
